// File: rtl/scan_decoder_if.sv
// rtl/scan_decoder_if.sv - signal bundle for the seven-segment bus monitor
interface scan_decoder_if;
    logic [7:0]  cs;
    logic [7:0]  seg;
    logic [39:0] digits_o;
    logic [7:0]  blank_o;
    logic        frame_valid;
    logic        decode_err;

    modport master (
        output cs, seg,
        input  digits_o, blank_o, frame_valid, decode_err
    );

    modport slave (
        input  cs, seg,
        output digits_o, blank_o, frame_valid, decode_err
    );
endinterface

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - passive seven-segment scan decoder, hex letters enabled by SCAN_DECODER_HEX_EN
module scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic          clk,
    input  logic          rst,
    scan_decoder_if.slave bus
);
    typedef enum logic {IDLE, COLLECT} state_t;

    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [7:0]  cs_s1, cs_s2, cs_p;
    logic [7:0]  seg_s1, seg_s2, seg_p;
    logic [15:0] settle_cnt;

    logic        sample;
    logic [3:0]  n_low;
    logic [2:0]  idx;
    logic        capture;
    logic        cs_err;
    logic [3:0]  dec_val;
    logic        dec_blank;
    logic        dec_bad;

    state_t      state;
    logic [7:0]  mask;
    logic [39:0] shadow_dig;
    logic [7:0]  shadow_blank;
    logic [31:0] tmo_cnt;
    logic [39:0] digits_r;
    logic [7:0]  blank_r;
    logic        frame_valid_r;
    logic        decode_err_r;

    // cs_p/seg_p hold the previous synchronized value; the sample is taken from
    // them, so a change arriving in the sample cycle cannot corrupt it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_s1      <= 8'hFF;
            cs_s2      <= 8'hFF;
            cs_p       <= 8'hFF;
            seg_s1     <= 8'hFF;
            seg_s2     <= 8'hFF;
            seg_p      <= 8'hFF;
            settle_cnt <= 16'd0;
        end else begin
            cs_s1  <= bus.cs;
            cs_s2  <= cs_s1;
            cs_p   <= cs_s2;
            seg_s1 <= bus.seg;
            seg_s2 <= seg_s1;
            seg_p  <= seg_s2;
            if ({cs_s2, seg_s2} != {cs_p, seg_p}) begin
                settle_cnt <= 16'd0;
            end else if (settle_cnt != 16'hFFFF) begin
                settle_cnt <= settle_cnt + 16'd1;
            end
        end
    end

    assign sample = (settle_cnt == SETTLE_LAST);

    always_comb begin
        n_low = 4'd0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!cs_p[i]) begin
                n_low = n_low + 4'd1;
                idx   = 3'(i);
            end
        end
    end

    assign capture = sample && (n_low == 4'd1);
    assign cs_err  = sample && (n_low > 4'd1);

    always_comb begin
        dec_val   = 4'd0;
        dec_blank = 1'b0;
        dec_bad   = 1'b0;
        case (seg_p[6:0])
            7'h40: dec_val = 4'd0;
            7'h79: dec_val = 4'd1;
            7'h24: dec_val = 4'd2;
            7'h30: dec_val = 4'd3;
            7'h19: dec_val = 4'd4;
            7'h12: dec_val = 4'd5;
            7'h02: dec_val = 4'd6;
            7'h78: dec_val = 4'd7;
            7'h00: dec_val = 4'd8;
            7'h10: dec_val = 4'd9;
            7'h7F: dec_blank = 1'b1;
`ifdef SCAN_DECODER_HEX_EN
            7'h08: dec_val = 4'hA;
            7'h03: dec_val = 4'hB;
            7'h46: dec_val = 4'hC;
            7'h21: dec_val = 4'hD;
            7'h06: dec_val = 4'hE;
            7'h0E: dec_val = 4'hF;
`endif
            default: dec_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            mask          <= 8'd0;
            shadow_dig    <= 40'd0;
            shadow_blank  <= 8'd0;
            tmo_cnt       <= 32'd0;
            digits_r      <= 40'd0;
            blank_r       <= 8'hFF;
            frame_valid_r <= 1'b0;
            decode_err_r  <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;
            if (cs_err || (capture && dec_bad)) begin
                decode_err_r <= 1'b1;
            end
            case (state)
                IDLE: begin
                    tmo_cnt <= 32'd0;
                    if (capture) begin
                        shadow_dig[int'(idx)*5 +: 5] <= {~seg_p[7], dec_val};
                        shadow_blank[idx]            <= dec_blank;
                        mask                         <= 8'(1) << idx;
                        state                        <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (mask == 8'hFF) begin
                        digits_r      <= shadow_dig;
                        blank_r       <= shadow_blank;
                        frame_valid_r <= 1'b1;
                        mask          <= 8'd0;
                        tmo_cnt       <= 32'd0;
                        state         <= IDLE;
                    end else if (capture) begin
                        shadow_dig[int'(idx)*5 +: 5] <= {~seg_p[7], dec_val};
                        shadow_blank[idx]            <= dec_blank;
                        tmo_cnt                      <= 32'd0;
                        // A repeated position means the driver began a new scan.
                        if (mask[idx]) begin
                            mask <= 8'(1) << idx;
                        end else begin
                            mask[idx] <= 1'b1;
                        end
                    end else if (tmo_cnt == TIMEOUT_LAST) begin
                        mask    <= 8'd0;
                        tmo_cnt <= 32'd0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.digits_o    = digits_r;
    assign bus.blank_o     = blank_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.decode_err  = decode_err_r;
endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - scoreboard bench for scan_decoder, honours SCAN_DECODER_HEX_EN
module tb_scan_decoder;
    localparam int SETTLE = 64;
    localparam int TMO    = 1000;
    localparam int DWELL  = 200;

`ifdef SCAN_DECODER_HEX_EN
    localparam logic [4:0] HEX_E_CODE = 5'h0E;
    localparam logic       HEX_E_ERR  = 1'b0;
`else
    localparam logic [4:0] HEX_E_CODE = 5'h00;
    localparam logic       HEX_E_ERR  = 1'b1;
`endif

    typedef struct packed {
        logic [39:0] dig;
        logic [7:0]  blk;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scan_decoder_if bus();

    scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    frame_t      sb[$];
    frame_t      exp_f;
    logic [39:0] prev_dig = 40'd0;
    logic [7:0]  seg_tab  [8];
    logic [4:0]  code_tab [8];
    logic [7:0]  blk_tab;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_frame(input int which);
        logic [7:0] s [8];
        logic [4:0] c [8];
        blk_tab = 8'h00;
        case (which)
            0: begin
                s = '{8'hF9, 8'h40, 8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'hC0, 8'hC0};
                c = '{5'h01, 5'h10, 5'h00, 5'h00, 5'h01, 5'h00, 5'h00, 5'h00};
            end
            1: begin
                s = '{8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'hFF};
                c = '{5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h00};
                blk_tab = 8'h80;
            end
            default: begin
                s = '{8'hF9, 8'h40, 8'hC0, 8'h86, 8'hF9, 8'hC0, 8'hC0, 8'hC0};
                c = '{5'h01, 5'h10, 5'h00, HEX_E_CODE, 5'h01, 5'h00, 5'h00, 5'h00};
            end
        endcase
        for (int i = 0; i < 8; i++) begin
            seg_tab[i]  = s[i];
            code_tab[i] = c[i];
        end
    endtask

    task automatic push_exp();
        frame_t f;
        f.dig = 40'd0;
        for (int i = 0; i < 8; i++) f.dig[5*i +: 5] = code_tab[i];
        f.blk = blk_tab;
        sb.push_back(f);
    endtask

    task automatic drive_digit(input int pos, input logic [7:0] s);
        @(posedge clk);
        bus.cs  = ~8'(1 << pos);
        bus.seg = s;
        repeat (DWELL - 1) @(posedge clk);
        bus.cs  = 8'hFF;
        bus.seg = 8'hFF;
        repeat (10) @(posedge clk);
    endtask

    task automatic scan(input int first, input int n);
        for (int k = 0; k < n; k++) drive_digit((first + k) % 8, seg_tab[(first + k) % 8]);
    endtask

    task automatic settle_and_check(input string tag);
        repeat (20) @(posedge clk);
        #1;
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_valid) begin
                if (sb.size() == 0) begin
                    check("frame_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_f = sb.pop_front();
                    check("frame_digits", 64'(bus.digits_o), 64'(exp_f.dig));
                    check("frame_blank", 64'(bus.blank_o), 64'(exp_f.blk));
                end
            end else if (bus.digits_o !== prev_dig) begin
                check("digits_hold", 64'(bus.digits_o), 64'(prev_dig));
            end
        end
        prev_dig = bus.digits_o;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, 64'(bus.digits_o), 64'd0);
        check({tag, "_blank"}, 64'(bus.blank_o), 64'hFF);
        check({tag, "_fv"}, 64'(bus.frame_valid), 64'd0);
        check({tag, "_err"}, 64'(bus.decode_err), 64'd0);
    endtask

    initial begin
        rst     = 1'b1;
        bus.cs  = 8'hFF;
        bus.seg = 8'hFF;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        rst = 1'b0;

        // Two clean scans, one frame each.
        set_frame(0);
        for (int r = 0; r < 2; r++) begin
            push_exp();
            scan(0, 8);
            settle_and_check("frame_a_seen");
        end
        check("frame_a_err", 64'(bus.decode_err), 64'd0);

        // Short glitch in the middle of position 0.
        push_exp();
        @(posedge clk);
        bus.cs  = 8'hFE;
        bus.seg = seg_tab[0];
        repeat (90) @(posedge clk);
        bus.seg = 8'h00;
        repeat (20) @(posedge clk);
        bus.seg = seg_tab[0];
        repeat (90) @(posedge clk);
        bus.cs  = 8'hFF;
        bus.seg = 8'hFF;
        repeat (10) @(posedge clk);
        scan(1, 7);
        settle_and_check("glitch_frame_seen");
        check("glitch_err", 64'(bus.decode_err), 64'd0);

        // Two digits selected at once.
        @(posedge clk);
        bus.cs  = 8'hFC;
        bus.seg = 8'hC0;
        repeat (100) @(posedge clk);
        bus.cs  = 8'hFF;
        bus.seg = 8'hFF;
        repeat (80) @(posedge clk);
        #1;
        check("cs_err_set", 64'(bus.decode_err), 64'd1);
        push_exp();
        scan(0, 8);
        settle_and_check("after_err_frame_seen");
        check("cs_err_sticky", 64'(bus.decode_err), 64'd1);

        // Restarted scan: only the full second pass publishes.
        scan(0, 4);
        set_frame(1);
        push_exp();
        scan(0, 8);
        settle_and_check("restart_frame_seen");

        // Partial scan abandoned; next scan starts mid-panel.
        set_frame(0);
        scan(0, 5);
        repeat (TMO + 200) @(posedge clk);
        set_frame(1);
        push_exp();
        scan(5, 8);
        settle_and_check("timeout_frame_seen");

        // Fresh reset, then a hex-letter pattern at position 3.
        @(posedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset2");
        @(posedge clk);
        rst = 1'b0;
        set_frame(2);
        push_exp();
        scan(0, 8);
        settle_and_check("hex_frame_seen");
        check("hex_err", 64'(bus.decode_err), 64'(HEX_E_ERR));

        // Reset in the middle of a frame discards the partial mask.
        set_frame(0);
        scan(0, 4);
        @(posedge clk);
        bus.cs  = 8'hEF;
        bus.seg = 8'hF9;
        repeat (100) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid");
        bus.cs  = 8'hFF;
        bus.seg = 8'hFF;
        @(posedge clk);
        rst = 1'b0;
        set_frame(1);
        scan(4, 4);
        repeat (TMO + 200) @(posedge clk);
        #1;
        check("reset_mid_no_frame", 64'(bus.frame_valid), 64'd0);
        set_frame(0);
        push_exp();
        scan(0, 8);
        settle_and_check("post_reset_frame_seen");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
